// File: rtl/mouse_proximity_tracker.sv
// mouse_proximity_tracker: per-frame scan of object positions against the latched mouse with hysteresis
// Ports: clk/rst (sync, active-high); start requests a scan; x_mouse/y_mouse signed Q20.12 mouse;
// obj_idx addresses the object store, obj_x/obj_y return one cycle later; busy during FETCH/EVAL;
// done pulses when close_mask/dir_mask/any_close/nearest_idx take the new scan's results.
module mouse_proximity_tracker #(
  parameter int N_OBJ     = 4,
  parameter int FRAC_BITS = 12,
  parameter int RADIUS    = 20,
  parameter int HYST      = 4,
  parameter int IDX_W     = N_OBJ > 1 ? $clog2(N_OBJ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      x_mouse,
  input  logic [31:0]      y_mouse,
  output logic [IDX_W-1:0] obj_idx,
  input  logic [31:0]      obj_x,
  input  logic [31:0]      obj_y,
  output logic             busy,
  output logic             done,
  output logic [N_OBJ-1:0] close_mask,
  output logic [N_OBJ-1:0] dir_mask,
  output logic             any_close,
  output logic [IDX_W-1:0] nearest_idx
);
  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_OBJ - 1);
  localparam logic [31:0]      R_IN  = 32'(RADIUS);
  localparam logic [31:0]      R_OUT = 32'(RADIUS + HYST);
  localparam logic [32:0]      SAT   = 33'h0_7FFF_FFFF;
  state_t state_q, state_d;
  logic [IDX_W-1:0] i_q, near_sh_q, near_sh_d, near_q;
  logic [31:0] xm_q, ym_q, min_q, min_d, axi, ayi, d, thr;
  logic [N_OBJ-1:0] close_sh_q, close_sh_d, dir_sh_q, dir_sh_d, close_q, dir_q;
  logic found_q, found_d, any_q, hit, take, last, accept, eval;
  logic [32:0] dx, dy, ax, ay;
  assign last   = i_q == LAST;
  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign eval   = state_q == EVAL;
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  always_comb
    state_d = state_q == FETCH ? EVAL :
              state_q == EVAL  ? (last ? DONE : FETCH) :
              start            ? FETCH : IDLE;
  always_comb begin
    busy = state_q == FETCH || state_q == EVAL;
    done = state_q == DONE;
  end
  // 33-bit differences cannot wrap; magnitudes saturate before dropping the fraction
  always_comb begin
    dx = {obj_x[31], obj_x} - {xm_q[31], xm_q};
    dy = {ym_q[31], ym_q} - {obj_y[31], obj_y};
    ax = dx[32] ? -dx : dx;
    ay = dy[32] ? -dy : dy;
    axi = (ax > SAT ? 32'h7FFF_FFFF : ax[31:0]) >> FRAC_BITS;
    ayi = (ay > SAT ? 32'h7FFF_FFFF : ay[31:0]) >> FRAC_BITS;
    d = axi > ayi ? axi : ayi;
    thr = close_q[i_q] ? R_OUT : R_IN;
    hit = axi < thr && ayi < thr;
    close_sh_d = close_sh_q;
    close_sh_d[i_q] = hit;
    dir_sh_d = dir_sh_q;
    dir_sh_d[i_q] = dx[32];
    take = hit && (!found_q || d < min_q);
    found_d = found_q | hit;
    near_sh_d = take ? i_q : near_sh_q;
    min_d = take ? d : min_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      i_q <= '0;
      xm_q <= '0;
      ym_q <= '0;
      close_sh_q <= '0;
      dir_sh_q <= '0;
      found_q <= 1'b0;
      near_sh_q <= '0;
      min_q <= '0;
      close_q <= '0;
      dir_q <= '0;
      any_q <= 1'b0;
      near_q <= '0;
    end else if (accept) begin
      i_q <= '0;
      xm_q <= x_mouse;
      ym_q <= y_mouse;
      close_sh_q <= '0;
      dir_sh_q <= '0;
      found_q <= 1'b0;
      near_sh_q <= '0;
      min_q <= '0;
    end else if (eval) begin
      close_sh_q <= close_sh_d;
      dir_sh_q <= dir_sh_d;
      found_q <= found_d;
      near_sh_q <= near_sh_d;
      min_q <= min_d;
      if (!last) i_q <= i_q + IDX_W'(1);
      else begin
        close_q <= close_sh_d;
        dir_q <= dir_sh_d;
        any_q <= |close_sh_d;
        near_q <= near_sh_d;
      end
    end
  assign obj_idx     = i_q;
  assign close_mask  = close_q;
  assign dir_mask    = dir_q;
  assign any_close   = any_q;
  assign nearest_idx = near_q;
endmodule

// File: doc/mouse_proximity_tracker.md
# mouse_proximity_tracker

Sequential, parametrised proximity engine for the cursor-interaction path. On each `start` pulse (typically once per frame) it latches the mouse position, scans `N_OBJ` object positions in Q20.12 fixed point through a one-cycle-latency read port, and applies a per-object box-distance test with hysteresis. It then commits a close mask, a direction mask, and the index of the nearest close object. It sits between the object position store and the game/render control logic.

## Interface
- `N_OBJ`, 4, number of objects scanned per pass (≥1)
- `FRAC_BITS`, 12, fractional bits of all coordinates
- `RADIUS`, 20, enter threshold in integer pixels
- `HYST`, 4, extra integer pixels an object may drift before it leaves the close state
- `IDX_W`, `N_OBJ>1 ? $clog2(N_OBJ) : 1`, index width (derived; do not override)

Ports:
- `clk`  in  1  clock; one clock domain
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  scan request; accepted only in IDLE or DONE
- `x_mouse`, `y_mouse`  in  32  signed Q20.12 mouse position
- `obj_idx`  out  IDX_W  object read address
- `obj_x`, `obj_y`  in  32  signed Q20.12 position of object `obj_idx`; valid one cycle after address
- `busy`  out  1  high in FETCH/EVAL
- `done`  out  1  one-cycle pulse; committed outputs are new in this cycle
- `close_mask`  out  N_OBJ  bit i = object i is close
- `dir_mask`  out  N_OBJ  bit i = sign of (obj_x − x_mouse), so 1 means the object is left of the mouse
- `any_close`  out  1  OR of `close_mask`
- `nearest_idx`  out  IDX_W  nearest close object

## Operation
- States: IDLE, FETCH, EVAL, DONE.
  - IDLE→FETCH on `start`.
  - FETCH→EVAL always.
  - EVAL→FETCH if i<N_OBJ−1, else →DONE.
  - DONE→FETCH on `start`, else →IDLE.
- On accepted `start`, latch `x_mouse`/`y_mouse` and set i=0. Mouse changes mid-scan are ignored.
- FETCH drives `obj_idx`=i. EVAL consumes `obj_x`/`obj_y`; `obj_idx` holds i through EVAL.
- Per object:
  - dx = obj_x − x_mouse_l and dy = y_mouse_l − obj_y, each sign-extended to 33 bits (no wrap).
  - ax = |dx| and ay = |dy|, each saturated to 2^31−1.
  - Integer parts: axi = ax >> FRAC_BITS and ayi = ay >> FRAC_BITS.
  - Chebyshev distance d = max(axi, ayi).
- Hysteresis uses committed bit prev = `close_mask[i]`:
  - prev=0: new=1 iff axi<RADIUS and ayi<RADIUS.
  - prev=1: new=1 iff axi<RADIUS+HYST and ayi<RADIUS+HYST.
- Direction bit = dx[32] for every object, close or not.
- Nearest: minimum d among objects with new=1. Ties go to the lowest index. If none is close, `nearest_idx`=0 and `any_close`=0.
- New bits and the running minimum accumulate in shadow registers. All result outputs commit together on the EVAL(N_OBJ−1)→DONE edge. Outputs never show a partial scan.
- `start` in FETCH/EVAL is ignored; it is not queued.

## Timing
- `start` high in cycle 0 gives FETCH(k) in cycle 2k+1, EVAL(k) in cycle 2k+2, and DONE with `done`=1 in cycle 2·N_OBJ+1.
- Latency is 2·N_OBJ+1 cycles. A back-to-back `start` in DONE yields one result every 2·N_OBJ+1 cycles.
- `busy` is high in cycles 1..2·N_OBJ. `done` is low except in DONE.
- Result outputs are registered and hold their values until the next DONE.
- Reset values: state IDLE; `obj_idx`, `busy`, `done`, `close_mask`, `dir_mask`, `any_close`, `nearest_idx` all 0.
- `rst` mid-scan returns to IDLE next cycle, zeroes all outputs and shadows, and discards hysteresis history. No `done` is produced for the aborted scan.
- `rst` and `start` in the same cycle: reset wins and `start` is dropped.

## Test plan
- N_OBJ=4, all coordinates ×2^12. Mouse (110,95), obj0 (100,100), others (500,500); start → `done` exactly at cycle 9, `close_mask`=0001, `dir_mask`=0001, `any_close`=1, `nearest_idx`=0, `busy` high cycles 1–8.
- Hysteresis on obj0:
  - Mouse at x=122 (axi=22) → stays close.
  - Mouse at x=124 (axi=24) → `close_mask[0]`=0.
  - Mouse back at x=121 (axi=21) → stays 0.
  - Mouse at x=119 (axi=19) → 1.
- Nearest tie: obj1 and obj3 both at d=5 and obj2 at d=7, all close → `nearest_idx`=1. With no object close → `nearest_idx`=0, `any_close`=0.
- Overflow: obj_x=0x8000_0000, x_mouse=0x7FFF_F000 → not close, `dir_mask` bit=1, no wraparound false hit.
- Control:
  - Mouse moved mid-scan → result uses the latched mouse position.
  - `start` pulsed during busy → ignored.
  - `start` in DONE → next `done` exactly 9 cycles later.
  - `rst` at cycle 5 → all outputs 0, no `done`, and a subsequent scan re-enters using the non-hysteresis RADIUS test.
